// File: rtl/stackcalc_cmd_feeder.sv
// stackcalc_cmd_feeder: buffers host commands and replays them onto the stackcalc pins with a stretched slow clock
module stackcalc_cmd_feeder #(
  parameter int DEPTH     = 4,
  parameter int SETUP_CYC = 2,
  parameter int HIGH_CYC  = 2,
  parameter int HOLD_CYC  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_mode,
  input  logic [3:0]               cmd_data,
  output logic [7:0]               pin_out,
  input  logic [7:0]               pin_in,
  output logic                     rsp_valid,
  output logic [7:0]               rsp_data,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int MC = (SETUP_CYC > HIGH_CYC) ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                                             : ((HIGH_CYC > HOLD_CYC) ? HIGH_CYC : HOLD_CYC);
  localparam int CW = $clog2(MC + 1);
  typedef enum logic [1:0] {IDLE, SETUP, HIGH, HOLD} state_t;
  state_t          state;
  logic [6:0]      mem [DEPTH];
  logic [AW-1:0]   wp, rp;
  logic [CW-1:0]   cnt;
  logic [6:0]      head;
  logic            push, pop;
  assign cmd_ready = fifo_count != (AW+1)'(DEPTH);
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state == IDLE) && (fifo_count != '0);
  assign busy      = (state != IDLE) || (fifo_count != '0);
  assign head      = mem[rp];
  // FIFO storage; entries are {mode, data}
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {cmd_mode, cmd_data};
  end
  // FIFO bookkeeping plus the pin sequencer; only pin_out[0] moves inside a command
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wp         <= '0;
      rp         <= '0;
      fifo_count <= '0;
      cnt        <= '0;
      pin_out    <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
    end else begin
      rsp_valid  <= 1'b0;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
      case (state)
        IDLE: if (pop) begin
          state   <= SETUP;
          cnt     <= CW'(SETUP_CYC - 1);
          pin_out <= {head[5:4], head[3:0], head[6], 1'b0};
        end
        SETUP: if (cnt == '0) begin
          state      <= HIGH;
          cnt        <= CW'(HIGH_CYC - 1);
          pin_out[0] <= 1'b1;
        end else cnt <= cnt - 1'b1;
        HIGH: if (cnt == '0) begin
          state      <= HOLD;
          cnt        <= CW'(HOLD_CYC - 1);
          pin_out[0] <= 1'b0;
        end else cnt <= cnt - 1'b1;
        HOLD: if (cnt == '0) begin
          state     <= IDLE;
          rsp_data  <= pin_in;
          rsp_valid <= 1'b1;
        end else cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stackcalc_cmd_feeder.sv
// tb_stackcalc_cmd_feeder: scoreboard bench for the stackcalc command feeder
module tb_stackcalc_cmd_feeder;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, cmd_valid, cmd_ready, rsp_valid, busy, use_const;
  logic [2:0] cmd_mode, fifo_count;
  logic [3:0] cmd_data;
  logic [7:0] pin_out, pin_in, rsp_data;
  logic v2, r2, rv2, b2;
  logic [2:0] m2, fc2;
  logic [3:0] d2;
  logic [7:0] po2, pi2, rd2;
  int vectors = 0, fails = 0, cyc = 0, hl = 0;
  logic [7:0] sb[$], sb2[$];
  int rsp_cyc[$], rises2[$], hlens[$];
  bit saw_full = 0, prv = 0, s = 0, ps2 = 0, pps2 = 0;
  logic [6:0] pd2 = '0;
  logic [6:0] tbl [6] = '{7'h01, 7'h7F, 7'h2C, 7'h55, 7'h3A, 7'h46};

  // Calculator stand-ins: a constant, a pin-dependent pattern, and an inverter for the second unit
  assign pin_in = use_const ? 8'h5C : ({pin_out[7:1], 1'b0} ^ 8'h3C);
  assign pi2 = ~po2;

  stackcalc_cmd_feeder u1 (.clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_data(cmd_data), .pin_out(pin_out), .pin_in(pin_in),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .fifo_count(fifo_count));

  stackcalc_cmd_feeder #(.DEPTH(4), .SETUP_CYC(1), .HIGH_CYC(3), .HOLD_CYC(1)) u2 (.clk(clk), .rst(rst),
    .cmd_valid(v2), .cmd_ready(r2), .cmd_mode(m2), .cmd_data(d2), .pin_out(po2), .pin_in(pi2),
    .rsp_valid(rv2), .rsp_data(rd2), .busy(b2), .fifo_count(fc2));

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic logic [7:0] pins(input logic [2:0] m, input logic [3:0] d);
    return {m[1:0], d, m[2], 1'b0};
  endfunction

  task automatic push(input logic [2:0] m, input logic [3:0] d, output int w);
    w = 0;
    cmd_valid = 1; cmd_mode = m; cmd_data = d;
    while (!cmd_ready && w < 100) begin @(posedge clk); #1; w++; end
    if (!cmd_ready) begin chk("push_timeout", 0, 1); cmd_valid = 0; return; end
    @(posedge clk);
    sb.push_back(use_const ? 8'h5C : pins(m, d) ^ 8'h3C);
    #1 cmd_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 500) begin @(posedge clk); #1; n++; end
    chk("drain_timeout", n < 500, 1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Response scoreboard and handshake invariants for the default unit
  always @(posedge clk) begin
    #1;
    if (rsp_valid) begin
      rsp_cyc.push_back(cyc);
      if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
      else chk("rsp_data", rsp_data, sb.pop_front());
    end
    if (prv) chk("rsp_pulse", rsp_valid, 0);
    prv = rsp_valid;
    chk("cmd_ready", cmd_ready, fifo_count != 3'd4);
    if (fifo_count == 3'd4 && !cmd_ready) saw_full = 1;
  end

  // Slow-clock shape and pin stability watcher for the retimed unit
  always @(posedge clk) begin
    #1;
    s = po2[0];
    if (rv2) begin
      if (sb2.size() == 0) chk("rsp2_unexpected", 1, 0);
      else chk("rsp2_data", rd2, sb2.pop_front());
    end
    if (s && !ps2) rises2.push_back(cyc);
    if (s) hl++;
    else if (ps2) begin hlens.push_back(hl); hl = 0; end
    if (po2[7:1] !== pd2) chk("pins2_stable", {ps2, pps2, s}, 0);
    pd2 = po2[7:1]; pps2 = ps2; ps2 = s;
  end

  initial begin
    int w, n;
    rst = 1; cmd_valid = 0; cmd_mode = 0; cmd_data = 0; use_const = 1;
    v2 = 0; m2 = 0; d2 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pin_out", pin_out, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    rst = 0; cmd_valid = 1; cmd_mode = 3'b101; cmd_data = 4'hA;
    @(posedge clk);
    sb.push_back(8'h5C);
    #1 cmd_valid = 0;
    chk("single_cnt_e0", fifo_count, 1);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      chk("single_sclk", pin_out[0], (k == 3 || k == 4));
      chk("single_pins", pin_out[7:1], 7'h35);
      chk("single_rsp_valid", rsp_valid, k == 7);
      if (k == 1) chk("single_cnt_e1", fifo_count, 0);
    end
    drain();
    use_const = 0; rsp_cyc.delete(); saw_full = 0;
    for (int i = 0; i < 6; i++) push(tbl[i][6:4], tbl[i][3:0], w);
    chk("burst_6th_waited", w > 0, 1);
    chk("burst_full_seen", saw_full, 1);
    drain();
    chk("burst_rsp_count", rsp_cyc.size(), 6);
    for (int i = 1; i < rsp_cyc.size(); i++) chk("burst_gap", rsp_cyc[i] - rsp_cyc[i-1], 7);
    for (int i = 0; i < 3; i++) push(tbl[5-i][6:4], tbl[5-i][3:0], w);
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("simul_rsp_seen", rsp_valid, 1);
    push(3'b100, 4'h5, w);
    chk("simul_no_wait", w, 0);
    chk("simul_cnt", fifo_count, 2);
    drain();
    for (int i = 0; i < 3; i++) push(tbl[i][6:4], tbl[i][3:0], w);
    n = 0;
    while (!pin_out[0] && n < 50) begin @(posedge clk); #1; n++; end
    chk("midrst_sclk_high", pin_out[0], 1);
    chk("midrst_queued", fifo_count, 2);
    rst = 1; sb.delete();
    @(posedge clk); #1;
    rst = 0;
    chk("midrst_pin_out", pin_out, 0);
    chk("midrst_fifo_count", fifo_count, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    repeat (20) @(posedge clk);
    #1;
    push(3'b010, 4'h9, w);
    drain();
    repeat (10) begin
      @(posedge clk); #1;
      chk("idle_pins", pin_out, pins(3'b010, 4'h9));
      chk("idle_busy", busy, 0);
      chk("idle_rsp_valid", rsp_valid, 0);
    end
    v2 = 1; m2 = 3'b110; d2 = 4'h3;
    @(posedge clk);
    sb2.push_back(~pins(m2, d2));
    #1 m2 = 3'b001; d2 = 4'hC;
    @(posedge clk);
    sb2.push_back(~pins(m2, d2));
    #1 v2 = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("t2_rises", rises2.size(), 2);
    if (rises2.size() == 2) chk("t2_period", rises2[1] - rises2[0], 6);
    chk("t2_high_runs", hlens.size(), 2);
    foreach (hlens[i]) chk("t2_high_len", hlens[i], 3);
    chk("t2_rsp_left", sb2.size(), 0);
    chk("t2_idle", b2, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
